// File: rtl/addsub_rr_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_rr_arbiter
//   Shares one saturating 16-bit signed add/sub unit between two requesters
//   (0 = ALU issue path, 1 = address/branch-offset path). Operation flow is
//   IDLE (arbitrate + capture) -> CALC (compute, register result) -> RESP
//   (hold result until consumed). Saturated results are counted.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/a0/b0/sub0       requester 0 request and operands; ack0 capture pulse
//   req1/a1/b1/sub1       requester 1 request and operands; ack1 capture pulse
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                requester owning the result
//   rsp_sum, rsp_ovf      saturated result and saturation flag
//   busy                  an operation is in flight
//   ovf_cnt               saturated-result counter, sticks at all-ones
// ---------------------------------------------------------------------------

// Saturating 16-bit signed adder/subtractor. exact_o is the full 17-bit
// result so the caller can derive overflow without looking at sum_o.
module addsub_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [16:0] exact_o,
    output logic [15:0] sum_o
);
    logic [16:0] a_ext_s;
    logic [16:0] b_ext_s;
    logic [16:0] exact_s;

    // Widen to 17 bits before operating: subtracting 0x8000 is then exact,
    // and the 17-bit range holds every possible sum or difference.
    always_comb begin
        a_ext_s = {a_i[15], a_i};
        b_ext_s = {b_i[15], b_i};
        if (sub_i) begin
            exact_s = a_ext_s - b_ext_s;
        end else begin
            exact_s = a_ext_s + b_ext_s;
        end
    end

    // Clamp: top two bits disagreeing means the value left the 16-bit range;
    // bit 16 gives the direction.
    always_comb begin
        if (!exact_s[16] && exact_s[15]) begin
            sum_o = 16'h7FFF;
        end else if (exact_s[16] && !exact_s[15]) begin
            sum_o = 16'h8000;
        end else begin
            sum_o = exact_s[15:0];
        end
    end

    assign exact_o = exact_s;
endmodule

module addsub_rr_arbiter #(
    parameter logic LAST_INIT = 1'b1,
    parameter int   OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [15:0]          a0,
    input  logic [15:0]          b0,
    input  logic                 sub0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [15:0]          a1,
    input  logic [15:0]          b1,
    input  logic                 sub1,
    output logic                 ack1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};
    localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_q,     state_d;
    logic                   last_gnt_q,  last_gnt_d;
    logic [15:0]            op_a_q,      op_a_d;
    logic [15:0]            op_b_q,      op_b_d;
    logic                   op_sub_q,    op_sub_d;
    logic                   op_id_q,     op_id_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_id_q,    rsp_id_d;
    logic [15:0]            rsp_sum_q,   rsp_sum_d;
    logic                   rsp_ovf_q,   rsp_ovf_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q,   ovf_cnt_d;

    logic                   gnt_any_s;
    logic                   gnt_id_s;
    logic [16:0]            calc_exact_s;
    logic [15:0]            calc_sum_s;
    logic                   calc_ovf_s;

    addsub_16bit u_addsub (
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sub_i   (op_sub_q),
        .exact_o (calc_exact_s),
        .sum_o   (calc_sum_s)
    );

    // Overflow flag taken from the exact 17-bit value, independent of the clamp.
    assign calc_ovf_s = calc_exact_s[16] ^ calc_exact_s[15];

    // Round-robin pick: on a tie the requester that did not win last time wins.
    always_comb begin
        gnt_any_s = req0 | req1;
        if (req0 && req1) begin
            gnt_id_s = ~last_gnt_q;
        end else if (req1) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
    end

    // Ack is combinational in the capture cycle; gated by rst_n so it is
    // quiet while reset is held.
    always_comb begin
        if (rst_n && (state_q == ST_IDLE) && gnt_any_s) begin
            ack0 = ~gnt_id_s;
            ack1 = gnt_id_s;
        end else begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

    // Next-state and datapath-register update.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;
        ovf_cnt_d   = ovf_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_d    = ST_CALC;
                    last_gnt_d = gnt_id_s;
                    op_id_d    = gnt_id_s;
                    op_a_d     = gnt_id_s ? a1 : a0;
                    op_b_d     = gnt_id_s ? b1 : b0;
                    op_sub_d   = gnt_id_s ? sub1 : sub0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_sum_d   = calc_sum_s;
                rsp_ovf_d   = calc_ovf_s;
                if (calc_ovf_s && (ovf_cnt_q != CNT_MAX)) begin
                    ovf_cnt_d = ovf_cnt_q + CNT_ONE;
                end else begin
                    ovf_cnt_d = ovf_cnt_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= LAST_INIT;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_sub_q    <= 1'b0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= 16'h0000;
            rsp_ovf_q   <= 1'b0;
            ovf_cnt_q   <= {OVF_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
module tb_addsub_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, sub0, req1, sub1, rsp_ready;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, rsp_valid, rsp_id, rsp_ovf, busy;
    logic [15:0] rsp_sum;
    logic [7:0]  ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1), .ack1(ack1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer math, then clamp to 16-bit signed range.
    task automatic ref_calc(input logic [15:0] a, input logic [15:0] b, input logic s,
                            output logic [15:0] sum, output logic ovf);
        int ex;
        ex = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        if (ex > 32767) begin
            sum = 16'h7FFF; ovf = 1'b1;
        end else if (ex < -32768) begin
            sum = 16'h8000; ovf = 1'b1;
        end else begin
            sum = ex[15:0]; ovf = 1'b0;
        end
    endtask

    // Transaction-level model: an op issued on an ack cycle is visible from
    // two cycles later until consumed; the unit accepts again the cycle after.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_last = 1'b1;
    int          m_cnt  = 0;
    bit          m_id   = 1'b0;
    logic [15:0] m_sum  = 16'h0000;
    logic        m_ovf  = 1'b0;

    always @(negedge clk) begin
        bit e0, e1, ev;
        if (!rst_n) begin
            chk("reset_outputs", {ack0, ack1, rsp_valid, rsp_id, rsp_ovf, busy, rsp_sum, ovf_cnt}, 64'h0);
            m_busy = 1'b0; m_last = 1'b1; m_cnt = 0; m_age = 0;
        end else begin
            e0 = !m_busy && req0 && (!req1 || m_last == 1'b1);
            e1 = !m_busy && req1 && (!req0 || m_last == 1'b0);
            ev = m_busy && (m_age >= 2);
            chk("model_ack", {ack0, ack1}, {e0, e1});
            chk("model_valid_busy", {rsp_valid, busy}, {ev, m_busy});
            chk("model_ovf_cnt", ovf_cnt, m_cnt);
            if (ev) chk("model_rsp", {rsp_id, rsp_ovf, rsp_sum}, {m_id, m_ovf, m_sum});
            if (!m_busy) begin
                if (e0 || e1) begin
                    m_id = e1;
                    if (e1) ref_calc(a1, b1, sub1, m_sum, m_ovf);
                    else    ref_calc(a0, b0, sub0, m_sum, m_ovf);
                    m_busy = 1'b1; m_age = 1; m_last = e1;
                end
            end else if (ev && rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
                if (m_age == 2 && m_ovf && m_cnt < 255) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Single op from one requester with literal-free capture of the result.
    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] sum, output logic ovf);
        bit got = 1'b0;
        rsp_ready = 1'b0;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) got = 1'b1;
            tick();
        end
        chk("op_ack_seen", got, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        got = 1'b0;
        sum = 16'hxxxx; ovf = 1'bx;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; sum = rsp_sum; ovf = rsp_ovf;
                chk("op_rsp_id", rsp_id, id);
            end
            tick();
        end
        chk("op_rsp_seen", got, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic rand_op(output logic [15:0] a, output logic [15:0] b, output logic s);
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 4) begin
            a = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
            b = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
            s = 1'b0;
        end else if (sel == 4) begin
            a = 16'($urandom); b = 16'h8000; s = 1'b1;
        end else begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        o;
        int          ops, cyc;
        bit          s0, s1, found;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
        a0 = 16'h0; b0 = 16'h0; sub0 = 1'b0; a1 = 16'h0; b1 = 16'h0; sub1 = 1'b0;
        @(negedge clk);
        chk("reset_state", {rsp_valid, busy, ovf_cnt, ack0, ack1}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: simple add, latency pinned by literals
        req0 = 1'b1; a0 = 16'h0003; b0 = 16'h0004; sub0 = 1'b0;
        @(negedge clk);
        chk("t1_ack0", {ack0, ack1}, 2'b10);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_calc_no_valid", rsp_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_sum}, {1'b1, 1'b0, 1'b0, 16'h0007});
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 2: both requesting after reset alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0001; sub0 = 1'b0;
        req1 = 1'b1; a1 = 16'h0020; b1 = 16'h0002; sub1 = 1'b1;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (ack0 || ack1) begin
                    found = 1'b1;
                    chk("t2_rr_grant", {ack0, ack1}, (g % 2 == 0) ? 2'b10 : 2'b01);
                end
                tick();
            end
            chk("t2_grant_seen", found, 1'b1);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        rsp_ready = 1'b0;

        // 3: saturation corners
        do_reset();
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, s, o);
        chk("t3_pos_sat", {o, s}, {1'b1, 16'h7FFF});
        run_op(1'b1, 16'h8000, 16'h0001, 1'b1, s, o);
        chk("t3_neg_sat", {o, s}, {1'b1, 16'h8000});
        run_op(1'b0, 16'h0000, 16'h8000, 1'b1, s, o);
        chk("t3_sub_min", {o, s}, {1'b1, 16'h7FFF});
        @(negedge clk);
        chk("t3_ovf_cnt", ovf_cnt, 8'd3);
        tick();

        // 4: stalled response with requester 1 waiting
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0101; sub0 = 1'b0;
        @(negedge clk);
        chk("t4_ack0", ack0, 1'b1);
        tick();
        req0 = 1'b0;
        req1 = 1'b1; a1 = 16'h0005; b1 = 16'h0002; sub1 = 1'b1;
        tick();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall", {rsp_valid, rsp_sum, ack1}, {1'b1, 16'h1335, 1'b0});
            tick();
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_handshake_no_ack", {rsp_valid, ack1}, 2'b10);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_ack1_after", ack1, 1'b1);
        tick();
        req1 = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;

        // 5: reset while computing
        req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0001; sub0 = 1'b0;
        @(negedge clk);
        chk("t5_ack0", ack0, 1'b1);
        tick();
        rst_n = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("t5_reset_valid", {rsp_valid, busy}, 2'b00);
        tick();
        @(negedge clk);
        chk("t5_no_delivery", rsp_valid, 1'b0);
        tick();
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_first_tie", {ack0, ack1}, 2'b10);
        tick();
        req0 = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("t5_ack1_next", ack1, 1'b1);
        tick();
        req1 = 1'b0;
        repeat (4) tick();
        rsp_ready = 1'b0;

        // 6: randomized traffic, checked by the model every cycle
        ops = 0; cyc = 0;
        while (ops < 1000 && cyc < 20000) begin
            @(negedge clk);
            s0 = ack0; s1 = ack1;
            ops += int'(s0) + int'(s1);
            tick();
            cyc++;
            if (s0) req0 = 1'b0;
            if (s1) req1 = 1'b0;
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin rand_op(a0, b0, sub0); req0 = 1'b1; end
            end else if ($urandom_range(0, 63) == 0) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin rand_op(a1, b1, sub1); req1 = 1'b1; end
            end else if ($urandom_range(0, 63) == 0) begin
                req1 = 1'b0;
            end
            rsp_ready = 1'($urandom_range(0, 1));
        end
        chk("t6_ops_done", (ops >= 1000), 1'b1);
        req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_ovf_cnt_sat", ovf_cnt, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
